// File: rtl/dtc_pkg.sv
// Shared sizing helpers and the stage payload carried down the dtc_pipe levels.
package dtc_pkg;

   // Payload fields are sized for the largest supported configuration; unused
   // high bits stay zero and are trimmed by synthesis.
   localparam int MAX_N_IN = 64;
   localparam int MAX_AW   = 9;

   typedef struct packed {
      logic                valid;
      logic [MAX_N_IN-1:0] sample;
      logic [MAX_AW-1:0]   node;
   } stage_t;

   function automatic int dtc_fi_w(input int n_in);
      return $clog2(n_in);
   endfunction

   function automatic int dtc_n_node(input int depth);
      return (1 << depth) - 1;
   endfunction

   function automatic int dtc_leaf_base(input int depth);
      return dtc_n_node(depth);
   endfunction

   function automatic int dtc_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/dtc_level.sv
// One tree level: selects the feature bit named by the incoming node and
// registers the sample together with the chosen child node.
module dtc_level
   import dtc_pkg::*;
#(
   parameter  int N_IN   = 12,
   parameter  int DEPTH  = 4,
   localparam int FI_W   = dtc_fi_w(N_IN),
   localparam int N_NODE = dtc_n_node(DEPTH)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             adv,
   input  logic [N_NODE-1:0][FI_W-1:0]      feat,
   input  stage_t                           d,
   output stage_t                           q
);

   logic [FI_W-1:0] f;
   logic            b;
   stage_t          nxt;

   // Feature indices at or beyond N_IN match no input bit, so b falls to 0.
   always_comb begin
      f = '0;
      for (int i = 0; i < N_NODE; i++) begin
         f = f | (feat[i] & {FI_W{d.node == MAX_AW'(i)}});
      end
      b = 1'b0;
      for (int j = 0; j < N_IN; j++) begin
         b = b | (d.sample[j] & (f == FI_W'(j)));
      end
      nxt      = d;
      nxt.node = {d.node[MAX_AW-2:0], 1'b0} + MAX_AW'(1) + MAX_AW'(b);
   end

   // Stage register shifts only when the whole pipe advances.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (adv) begin
         q <= nxt;
      end
   end

endmodule

// File: rtl/dtc_pipe.sv
// Runtime-programmable decision-tree classifier, one pipeline stage per tree
// level, with a writable node/leaf table and valid/ready streaming.
module dtc_pipe
   import dtc_pkg::*;
#(
   parameter  int N_IN   = 12,
   parameter  int DEPTH  = 4,
   parameter  int CLS_W  = 3,
   localparam int FI_W   = dtc_fi_w(N_IN),
   localparam int N_NODE = dtc_n_node(DEPTH),
   localparam int N_LEAF = N_NODE + 1,
   localparam int AW     = DEPTH + 1,
   localparam int CFG_W  = dtc_max(FI_W, CLS_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_IN-1:0]   inp,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CLS_W-1:0]  outp,
   input  logic              cfg_we,
   input  logic [AW-1:0]     cfg_addr,
   input  logic [CFG_W-1:0]  cfg_data,
   output logic              busy
);

   localparam int LEAF_BASE = dtc_leaf_base(DEPTH);

   logic [N_NODE-1:0][FI_W-1:0]  feat;
   logic [N_LEAF-1:0][CLS_W-1:0] leaf;
   stage_t                       head;
   stage_t                       lvl_in [DEPTH];
   stage_t                       st     [DEPTH];
   stage_t                       last;
   logic [CLS_W-1:0]             cls;
   logic                         adv;
   logic                         unused_tail;

   assign adv         = !out_valid || out_ready;
   assign in_ready    = adv && !cfg_we;
   assign last        = st[DEPTH-1];
   assign unused_tail = ^{last.sample, last.valid};

   // Addresses past the last leaf match no entry and are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         feat <= '0;
         leaf <= '0;
      end else if (cfg_we) begin
         for (int i = 0; i < N_NODE; i++) begin
            if (cfg_addr == AW'(i)) feat[i] <= cfg_data[FI_W-1:0];
         end
         for (int i = 0; i < N_LEAF; i++) begin
            if (cfg_addr == AW'(LEAF_BASE + i)) leaf[i] <= cfg_data[CLS_W-1:0];
         end
      end
   end

   // Level 0 starts from the root with the sample taken straight off inp.
   always_comb begin
      head        = '0;
      head.valid  = in_valid && in_ready;
      head.sample = MAX_N_IN'(inp);
   end

   generate
      for (genvar s = 0; s < DEPTH; s++) begin : g_level
         if (s == 0) begin : g_head
            assign lvl_in[s] = head;
         end else begin : g_chain
            assign lvl_in[s] = st[s-1];
         end
         dtc_level #(.N_IN(N_IN), .DEPTH(DEPTH)) u_level (
            .clk   (clk),
            .rst_n (rst_n),
            .adv   (adv),
            .feat  (feat),
            .d     (lvl_in[s]),
            .q     (st[s])
         );
      end
   endgenerate

   // Leaf class lookup for the node leaving the last level.
   always_comb begin
      cls = '0;
      for (int i = 0; i < N_LEAF; i++) begin
         cls = cls | (leaf[i] & {CLS_W{last.node == MAX_AW'(LEAF_BASE + i)}});
      end
   end

   // Output register follows the same advance as the stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         outp      <= '0;
      end else if (adv) begin
         out_valid <= last.valid;
         outp      <= cls;
      end
   end

   // Any valid stage or a pending output keeps the pipe busy.
   always_comb begin
      busy = out_valid;
      for (int s = 0; s < DEPTH; s++) begin
         busy = busy | st[s].valid;
      end
   end

endmodule

// File: tb/tb_dtc_pipe.sv
// Randomised self-checking bench for dtc_pipe against a tree-walking model.
module tb_dtc_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [11:0] inp = 12'h000;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [2:0]  outp;
   logic        cfg_we = 1'b0;
   logic [4:0]  cfg_addr = 5'd0;
   logic [3:0]  cfg_data = 4'd0;
   logic        busy;

   int errors = 0;
   int checks = 0;

   int         feat_m [15];
   logic [2:0] leaf_m [16];
   logic [2:0] exp_q [$];
   logic [2:0] obs_q [$];

   dtc_pipe #(.N_IN(12), .DEPTH(4), .CLS_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .inp       (inp),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .outp      (outp),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] predict(input logic [11:0] s);
      int n;
      n = 0;
      for (int l = 0; l < 4; l++) begin
         int f;
         int b;
         f = feat_m[n];
         b = (f < 12) ? int'(s[f]) : 0;
         n = 2 * n + 1 + b;
      end
      return leaf_m[n - 15];
   endfunction

   function automatic void model_write(input logic [4:0] a, input logic [3:0] d);
      if (a < 5'd15) feat_m[a] = int'(d);
      else if (a <= 5'd30) leaf_m[a - 5'd15] = d[2:0];
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 15; i++) feat_m[i] = 0;
      for (int i = 0; i < 16; i++) leaf_m[i] = 3'd0;
      exp_q.delete();
      obs_q.delete();
   endfunction

   // Records accepted samples, completed outputs and table writes edge by edge.
   always @(posedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) exp_q.push_back(predict(inp));
         if (out_valid && out_ready) obs_q.push_back(outp);
         if (cfg_we) model_write(cfg_addr, cfg_data);
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [4:0] a, input logic [3:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      cycle();
      cfg_we = 1'b0;
   endtask

   task automatic program_base();
      for (int a = 0; a < 15; a++) begin
         cfg_write(5'(a), (a == 0) ? 4'd6 : (a < 3) ? 4'd3 : (a < 7) ? 4'd9 : 4'd0);
      end
      for (int a = 15; a < 31; a++) cfg_write(5'(a), 4'((a - 15) % 8));
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 50 && busy; i++) cycle();
   endtask

   task automatic send_one(input logic [11:0] s, output logic [2:0] cls, output bit ok);
      bit acc;
      ok = 1'b0; cls = 3'd0; acc = 1'b0;
      in_valid = 1'b1; inp = s; out_ready = 1'b1;
      for (int i = 0; i < 20 && !acc; i++) begin
         #1;
         acc = in_ready;
         cycle();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 20 && acc && !ok; i++) begin
         if (out_valid) begin
            cls = outp; ok = 1'b1;
         end
         cycle();
      end
   endtask

   task automatic do_reset();
      in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
      #1 rst_n = 1'b0;
      model_clear();
      repeat (2) cycle();
      @(negedge clk) rst_n = 1'b1;
      cycle();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (outp !== 3'd0) begin errors++; $display("FAIL reset_outp: got %0d expected 0", outp); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_paths();
      logic [11:0] pin [3];
      logic [2:0]  pcls [3];
      pin  = '{12'h000, 12'h249, 12'h041};
      pcls = '{3'd0, 3'd7, 3'd1};
      for (int k = 0; k < 3; k++) begin
         wait_idle();
         in_valid = 1'b1; inp = pin[k]; out_ready = 1'b1;
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL path_in_ready: got %b expected 1", in_ready); end
         cycle();
         in_valid = 1'b0;
         for (int i = 1; i <= 4; i++) begin
            cycle();
            checks++;
            if (out_valid !== (i == 4)) begin
               errors++; $display("FAIL path_latency: edge +%0d out_valid %b expected %b", i, out_valid, (i == 4));
            end
         end
         checks++; if (outp !== pcls[k]) begin errors++; $display("FAIL path_outp: inp %h got %0d expected %0d", pin[k], outp, pcls[k]); end
         cycle();
      end
   endtask

   task automatic test_back_to_back();
      int cnt, first, last_c;
      wait_idle();
      exp_q.delete(); obs_q.delete();
      cnt = 0; first = -1; last_c = -1;
      for (int c = 0; c < 30; c++) begin
         in_valid = (c < 8); inp = 12'($urandom); out_ready = 1'b1;
         #1;
         if (c < 8) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready: cycle %0d got %b expected 1", c, in_ready); end
         end
         if (out_valid) begin
            cnt++; if (first < 0) first = c; last_c = c;
         end
         cycle();
      end
      in_valid = 1'b0;
      checks++; if (cnt != 8 || last_c - first + 1 != 8) begin errors++; $display("FAIL stream_rate: %0d outputs over %0d cycles expected 8 over 8", cnt, last_c - first + 1); end
      checks++; if (obs_q.size() != 8 || exp_q.size() != 8) begin errors++; $display("FAIL stream_count: got %0d outputs expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < 8 && i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL stream_data: idx %0d got %0d expected %0d", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_backpressure();
      int sent;
      logic [2:0] held;
      wait_idle();
      exp_q.delete(); obs_q.delete();
      sent = 0; held = 3'd0;
      for (int c = 0; c < 40; c++) begin
         out_ready = !(c >= 8 && c < 13);
         in_valid = (sent < 12); inp = 12'($urandom);
         #1;
         if (c == 8) held = outp;
         if (c >= 8 && c < 13) begin
            checks++; if (out_valid !== 1'b1 || outp !== held) begin errors++; $display("FAIL stall_outp: cycle %0d valid %b outp %0d expected 1 %0d", c, out_valid, outp, held); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: cycle %0d got %b expected 0", c, in_ready); end
         end
         if (in_valid && in_ready) sent++;
         cycle();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (obs_q.size() != 12 || exp_q.size() != 12) begin errors++; $display("FAIL stall_count: got %0d outputs from %0d accepted expected 12", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_data: idx %0d got %0d expected %0d", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_boundary();
      logic [2:0]  cls;
      logic [11:0] s;
      bit          ok;
      wait_idle();
      cfg_write(5'd0, 4'hD);
      send_one(12'hFFF, cls, ok);
      checks++; if (!ok || cls !== 3'd7) begin errors++; $display("FAIL root_out_of_range: ok %0d got %0d expected 7", ok, cls); end
      cfg_write(5'd31, 4'h5);
      send_one(12'hFFF, cls, ok);
      checks++; if (!ok || cls !== 3'd7) begin errors++; $display("FAIL addr31_fff: ok %0d got %0d expected 7", ok, cls); end
      send_one(12'h000, cls, ok);
      checks++; if (!ok || cls !== 3'd0) begin errors++; $display("FAIL addr31_000: ok %0d got %0d expected 0", ok, cls); end
      for (int i = 0; i < 4; i++) begin
         s = 12'($urandom);
         send_one(s, cls, ok);
         checks++; if (!ok || cls !== predict(s)) begin errors++; $display("FAIL boundary_random: inp %h got %0d expected %0d", s, cls, predict(s)); end
      end
   endtask

   task automatic test_reset_midstream();
      logic [2:0] cls;
      bit         ok;
      wait_idle();
      program_base();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; inp = 12'($urandom);
         cycle();
      end
      in_valid = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL inflight_busy: got %b expected 1", busy); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b expected 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
      model_clear();
      @(negedge clk) rst_n = 1'b1;
      repeat (6) cycle();
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL midreset_drop: got %0d outputs expected 0", obs_q.size()); end
      send_one(12'hFFF, cls, ok);
      checks++; if (!ok || cls !== 3'd0) begin errors++; $display("FAIL table_cleared: ok %0d got %0d expected 0", ok, cls); end
   endtask

   task automatic test_cfg_collision();
      logic [11:0] s;
      bit          seen;
      program_base();
      wait_idle();
      exp_q.delete(); obs_q.delete();
      s = 12'($urandom);
      cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 4'd3;
      in_valid = 1'b1; inp = s;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL collide_in_ready: got %b expected 0", in_ready); end
      cycle();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL collide_accept: got %0d accepted expected 0", exp_q.size()); end
      cfg_we = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL collide_next_ready: got %b expected 1", in_ready); end
      cycle();
      in_valid = 1'b0;
      checks++; if (exp_q.size() != 1) begin errors++; $display("FAIL collide_next_accept: got %0d accepted expected 1", exp_q.size()); end
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         if (out_valid) seen = 1'b1; else cycle();
      end
      checks++; if (!seen || outp !== predict(s)) begin errors++; $display("FAIL collide_outp: seen %0d got %0d expected %0d", seen, outp, predict(s)); end
      cycle();
   endtask

   initial begin
      test_reset();
      program_base();
      test_paths();
      test_back_to_back();
      test_backpressure();
      test_boundary();
      test_reset_midstream();
      test_cfg_collision();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached at %0t expected completion", $time);
      $fatal(1, "watchdog");
   end

endmodule
